mouse_to_quad: RTL
==================

MOUSE_TO_QUAD -- requirements
Module: mouse_to_quad

Interface
REQ-001 CLKDIV, default 5500: step-tick period in CLK cycles; legal range 2..65535.
REQ-002 ACC_W, default 10: signed width of the pending-motion accumulator.
REQ-003 CLK  input  1: single clock; all state is updated on its rising edge.
REQ-004 Reset_n  input  1: reset, synchronous and active-low.
REQ-005 ps2_mouse  input  25: hps_io mouse word with these fields:
- [24] toggles once per packet.
- [15:8] X magnitude.
- [4] X sign.
- [0] left button.
REQ-006 left  input  1: digital left request, active high.
REQ-007 right  input  1: digital right request, active high.
REQ-008 steer  output  2: quadrature phases {A,B}, registered.
REQ-009 btn  output  1: left mouse button as captured from the latest packet, registered.

Function
REQ-010 Packet detect: a packet is accepted in every cycle where ps2_mouse[24] differs from its value registered on the previous cycle; exactly one accept per toggle.
REQ-011 Packet delta: the delta is the 9-bit two's-complement value {ps2_mouse[4], ps2_mouse[15:8]}, range -256..+255.
REQ-012 Button capture: on accept, btn takes ps2_mouse[0]; between accepts btn holds its value.
REQ-013 Tick divider:
- Counts 0..CLKDIV-1.
- tick is asserted in the cycle where the count equals CLKDIV-1.
- The count wraps to 0 in the following cycle.
REQ-014 Step direction on tick, first matching row wins:
- right=1, left=0: +1, accumulator not consumed.
- left=1, right=0: -1, accumulator not consumed.
- accumulator>0: +1, consumes one count.
- accumulator<0: -1, consumes one count.
- Otherwise: no step.
- left=1 and right=1 together is treated as no joystick input.
REQ-015 Accumulator next value = sat(acc + delta_if_accepted - consumed_step).
- The sum is computed at ACC_W+2 bits.
- Saturation limits are -(2^(ACC_W-1)-1) and +(2^(ACC_W-1)-1), i.e. ±511 at default.
REQ-016 Simultaneous accept and consuming step in one cycle: both terms are applied in that same cycle; neither is lost or deferred.
REQ-017 Quadrature sequence:
- +1 advances steer 00→01→11→10→00.
- -1 walks the same sequence in reverse.
- steer changes exactly one bit per step.
REQ-018 Latency: steer updates on the clock edge that ends the tick cycle; at most one step per tick.
REQ-019 No steps occur outside tick cycles, so the step rate is never above CLK/CLKDIV.
REQ-020 State encoding: the quadrature phase is a 2-bit state register, and steer is that register.

Reset
REQ-021 While Reset_n=0 at a clock edge, the following take these values:
- steer=00
- btn=0
- accumulator=0
- divider=0
REQ-022 During reset, the registered toggle copy is loaded from ps2_mouse[24], so deasserting reset causes no spurious accept.
REQ-023 Reset asserted mid-stream discards all pending motion; the first tick after release occurs CLKDIV cycles after release.
REQ-024 Packets arriving while Reset_n=0 are ignored.

Verification
REQ-025 CLKDIV=4; one packet with X=+3, sign 0 → steer sequence 00→01→11→10 on three consecutive ticks, then static; accumulator 0.
REQ-026 One packet with sign 1, X=0xFE (-2) → steer 00→10→11; btn follows bit0 of the packet.
REQ-027 Three packets of +255 back-to-back, ACC_W=10 → accumulator saturates at +511; exactly 511 forward steps follow, then no more.
REQ-028 Accumulator=+5 with right held for 10 ticks → 10 forward steps, accumulator stays 5; after release, 5 more forward steps follow.
REQ-029 Packet accept and consuming tick in the same cycle, accumulator=+1, delta=+1 → accumulator=+1 next cycle and one step emitted.
REQ-030 Reset_n pulsed low for 1 cycle while accumulator=+100 and ps2_mouse[24]=1 held → steer=00 and accumulator=0; no step and no accept follow until a new toggle arrives.

Source files
------------

// File: rtl/mouse_to_quad.sv
// Converts hps_io mouse X motion (plus digital left/right requests) into a
// rate-limited quadrature pair {A,B}, one step per divider tick at most.
module mouse_to_quad #(
  parameter int CLKDIV = 5500,
  parameter int ACC_W  = 10
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic [24:0]             ps2_mouse,
  input  logic                    left,
  input  logic                    right,
  output logic [1:0]              steer,
  output logic                    btn,
  output logic signed [ACC_W-1:0] acc_dbg
);

  localparam int SW        = ACC_W + 2;
  localparam int SAT_MAX_I = (1 << (ACC_W - 1)) - 1;
  localparam logic signed [SW-1:0] SAT_HI = SW'(SAT_MAX_I);
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;
  localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);

  // Gray-ordered phases: forward walks PH0->PH1->PH2->PH3->PH0.
  typedef enum logic [1:0] {
    PH0 = 2'b00,
    PH1 = 2'b01,
    PH2 = 2'b11,
    PH3 = 2'b10
  } phase_t;

  phase_t                  phase_q, phase_d;
  logic                    tog_q;
  logic                    btn_q;
  logic [15:0]             div_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic                    accept;
  logic                    tick;
  logic signed [8:0]       delta;
  logic                    joy_r, joy_l;
  logic                    step_up, step_dn;
  logic signed [1:0]       consume;
  logic signed [SW-1:0]    delta_ext;
  logic signed [SW-1:0]    sum;

  logic unused_bits;
  assign unused_bits = ^{ps2_mouse[23:16], ps2_mouse[7:5], ps2_mouse[3:1]};

  assign accept = ps2_mouse[24] ^ tog_q;
  assign delta  = {ps2_mouse[4], ps2_mouse[15:8]};
  assign tick   = (div_q == DIV_LAST);
  assign joy_r  = right & ~left;
  assign joy_l  = left & ~right;

  // Joystick requests win over pending mouse motion and leave it untouched.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    consume = 2'sd0;
    if (tick) begin
      if (joy_r) begin
        step_up = 1'b1;
      end else if (joy_l) begin
        step_dn = 1'b1;
      end else if (acc_q > 0) begin
        step_up = 1'b1;
        consume = 2'sd1;
      end else if (acc_q < 0) begin
        step_dn = 1'b1;
        consume = -2'sd1;
      end
    end
  end

  // A same-cycle packet and consuming step are both folded in here.
  always_comb begin
    delta_ext = accept ? SW'(delta) : '0;
    sum       = SW'(acc_q) + delta_ext - SW'(consume);
    if (sum > SAT_HI) begin
      acc_d = SAT_HI[ACC_W-1:0];
    end else if (sum < SAT_LO) begin
      acc_d = SAT_LO[ACC_W-1:0];
    end else begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    tog_q <= ps2_mouse[24];
    if (!Reset_n) begin
      btn_q <= 1'b0;
      div_q <= '0;
      acc_q <= '0;
    end else begin
      if (accept) btn_q <= ps2_mouse[0];
      div_q <= tick ? '0 : div_q + 16'd1;
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) phase_q <= PH0;
    else          phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (step_up) begin
      case (phase_q)
        PH0:     phase_d = PH1;
        PH1:     phase_d = PH2;
        PH2:     phase_d = PH3;
        default: phase_d = PH0;
      endcase
    end else if (step_dn) begin
      case (phase_q)
        PH0:     phase_d = PH3;
        PH3:     phase_d = PH2;
        PH2:     phase_d = PH1;
        default: phase_d = PH0;
      endcase
    end
  end

  always_comb begin
    steer   = phase_q;
    btn     = btn_q;
    acc_dbg = acc_q;
  end

endmodule
